// File: rtl/rgb_frame_sched.sv
// rgb_frame_sched: frame scheduler in front of the rgb2yuv colour converter.
//
// Accepts an RGB pixel stream (ready/valid, tuser = start of frame, tlast = end
// of line), checks every frame against a fixed WIDTH x HEIGHT geometry, drops
// malformed or unrequested data and forwards clean frames with one cycle of
// latency. Backpressure from downstream drives the converter's wait input.
//
// Ports:
//   clk, n_rst             clock, synchronous active-low reset
//   i_enable               frame acceptance enable, sampled only at SOF
//   s_tdata/tvalid/tuser/tlast, s_tready   input stream
//   m_ready                downstream ready
//   o_wait                 to converter i_wait (= !m_ready)
//   o_tdata/tvalid/tuser/tlast              forwarded stream to converter
//   o_busy                 high while a frame is in progress
//   o_frame_done           pulse after the last pixel of a frame is accepted
//   o_err, o_err_code      error pulse; code 01 early tlast, 10 missing tlast,
//                          11 unexpected tuser (code held until next error)
//   o_frame_cnt, o_err_cnt statistics counters
//
// Optional feature: define RGB_FRAME_SCHED_STATS_EN to build the frame and
// error counters; otherwise both outputs are tied to 0.

module rgb_frame_sched #(
  parameter int unsigned PIXEL_BITWIDTH = 24,
  parameter int unsigned WIDTH          = 640,
  parameter int unsigned HEIGHT         = 480,
  parameter int unsigned CNT_BITWIDTH   = 12
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      i_enable,
  input  logic [PIXEL_BITWIDTH-1:0] s_tdata,
  input  logic                      s_tvalid,
  input  logic                      s_tuser,
  input  logic                      s_tlast,
  output logic                      s_tready,
  input  logic                      m_ready,
  output logic                      o_wait,
  output logic [PIXEL_BITWIDTH-1:0] o_tdata,
  output logic                      o_tvalid,
  output logic                      o_tuser,
  output logic                      o_tlast,
  output logic                      o_busy,
  output logic                      o_frame_done,
  output logic                      o_err,
  output logic [1:0]                o_err_code,
  output logic [15:0]               o_frame_cnt,
  output logic [15:0]               o_err_cnt
);

  typedef enum logic [1:0] {StIdle, StActive, StResync} state_e;

  localparam logic [CNT_BITWIDTH-1:0] ColLast = CNT_BITWIDTH'(WIDTH - 1);
  localparam logic [CNT_BITWIDTH-1:0] RowLast = CNT_BITWIDTH'(HEIGHT - 1);

  state_e                    state_q, state_d;
  logic [CNT_BITWIDTH-1:0]   col_q, col_d;
  logic [CNT_BITWIDTH-1:0]   row_q, row_d;
  logic [PIXEL_BITWIDTH-1:0] tdata_q;
  logic                      tvalid_q, tuser_q, tlast_q;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic [1:0]                code_q, code_d;
  logic                      accept, fwd;

  assign s_tready = n_rst & m_ready;
  assign o_wait   = ~m_ready;
  assign accept   = s_tvalid & s_tready;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    fwd     = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    if (accept) begin
      case (state_q)
        StActive: begin
          if (s_tuser) begin
            // Unexpected SOF restarts the frame; it wins over any tlast fault.
            err_d  = 1'b1;
            code_d = 2'b11;
            if (i_enable) begin
              fwd   = 1'b1;
              col_d = CNT_BITWIDTH'(1);
              row_d = '0;
            end else begin
              state_d = StResync;
            end
          end else if (s_tlast && (col_q != ColLast)) begin
            err_d   = 1'b1;
            code_d  = 2'b01;
            state_d = StResync;
          end else if (!s_tlast && (col_q == ColLast)) begin
            err_d   = 1'b1;
            code_d  = 2'b10;
            state_d = StResync;
          end else begin
            fwd = 1'b1;
            if (s_tlast) begin
              col_d = '0;
              if (row_q == RowLast) begin
                row_d   = '0;
                done_d  = 1'b1;
                state_d = StIdle;
              end else begin
                row_d = row_q + 1'b1;
              end
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
        default: begin
          // Idle and resync both wait for an SOF beat and drop everything else.
          if (s_tuser) begin
            if (i_enable) begin
              fwd     = 1'b1;
              col_d   = CNT_BITWIDTH'(1);
              row_d   = '0;
              state_d = StActive;
            end else begin
              state_d = StResync;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q  <= StIdle;
      col_q    <= '0;
      row_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tuser_q  <= 1'b0;
      tlast_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
      // Outputs freeze while downstream stalls so the converter sees a stable beat.
      if (m_ready) begin
        tvalid_q <= fwd;
        tuser_q  <= fwd & s_tuser;
        tlast_q  <= fwd & s_tlast;
        if (fwd) begin
          tdata_q <= s_tdata;
        end
      end
    end
  end

  assign o_tdata      = tdata_q;
  assign o_tvalid     = tvalid_q;
  assign o_tuser      = tuser_q;
  assign o_tlast      = tlast_q;
  assign o_busy       = (state_q == StActive);
  assign o_frame_done = done_q;
  assign o_err        = err_q;
  assign o_err_code   = code_q;

`ifdef RGB_FRAME_SCHED_STATS_EN
  logic [15:0] frame_cnt_q, err_cnt_q;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (done_d) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (err_d)  err_cnt_q   <= err_cnt_q + 16'd1;
    end
  end

  assign o_frame_cnt = frame_cnt_q;
  assign o_err_cnt   = err_cnt_q;
`else
  assign o_frame_cnt = '0;
  assign o_err_cnt   = '0;
`endif

endmodule
